// File: rtl/mem_port_arbiter.sv
// Arbitrates the mips_cpu fetch and data channels onto one memory port,
// one transaction in flight at a time, with round-robin tie-breaking.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // Fetch channel
    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ack,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ack,
    // Data channel
    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    output logic                Mem_Req_Ack,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ack,
    // Unified memory port
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                mem_rsp_ready,
    // Performance counters
    output logic [31:0]         arb_wait_cnt,
    output logic [31:0]         arb_tx_cnt
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = fetch, 1 = data
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                wr_q, wr_d;
    logic [31:0]         wait_cnt_q, wait_cnt_d;
    logic [31:0]         tx_cnt_q, tx_cnt_d;

    logic dreq;
    logic grant_data;
    logic cpu_ack;
    logic wait_inc;
    logic tx_inc;

    assign dreq = MemRead | MemWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_q       <= 1'b0;
            wait_cnt_q <= '0;
            tx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_q       <= wr_d;
            wait_cnt_q <= wait_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        wr_d            = wr_q;
        grant_data      = 1'b0;
        mem_req_valid   = 1'b0;
        Inst_Req_Ack    = 1'b0;
        Mem_Req_Ack     = 1'b0;
        Inst_Valid      = 1'b0;
        Read_data_Valid = 1'b0;
        mem_rsp_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Inst_Req_Valid || dreq) begin
                    // On a tie the channel not served last time wins.
                    grant_data = dreq && (!Inst_Req_Valid || !last_q);
                    owner_d    = grant_data;
                    last_d     = grant_data;
                    if (grant_data) begin
                        addr_d  = Address;
                        wdata_d = Write_data;
                        wstrb_d = Write_strb;
                        wr_d    = MemWrite;
                    end else begin
                        addr_d  = PC;
                        wdata_d = '0;
                        wstrb_d = '0;
                        wr_d    = 1'b0;
                    end
                    state_d = REQ;
                end
            end

            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    Inst_Req_Ack = !owner_q;
                    Mem_Req_Ack  = owner_q;
                    state_d      = wr_q ? IDLE : RSP;
                end
            end

            RSP: begin
                Inst_Valid      = mem_rsp_valid && !owner_q;
                Read_data_Valid = mem_rsp_valid && owner_q;
                mem_rsp_ready   = owner_q ? Read_data_Ack : Inst_Ack;
                if (mem_rsp_valid && mem_rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pending CPU request counts as waiting in every cycle it is not acked.
    assign cpu_ack    = Inst_Req_Ack | Mem_Req_Ack;
    assign wait_inc   = (Inst_Req_Valid | dreq) & ~cpu_ack;
    assign tx_inc     = mem_req_valid & mem_req_ready;
    assign wait_cnt_d = wait_cnt_q + {31'd0, wait_inc};
    assign tx_cnt_d   = tx_cnt_q + {31'd0, tx_inc};

    assign mem_req_wr   = wr_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign Instruction  = mem_rsp_data;
    assign Read_data    = mem_rsp_data;
    assign arb_wait_cnt = wait_cnt_q;
    assign arb_tx_cnt   = tx_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the
// rising edge, outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_ready;
    logic [31:0] arb_wait_cnt;
    logic [31:0] arb_tx_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .arb_wait_cnt(arb_wait_cnt), .arb_tx_cnt(arb_tx_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        PC = '0; Inst_Req_Valid = 0; Inst_Ack = 0;
        Address = '0; MemRead = 0; MemWrite = 0; Write_data = '0; Write_strb = '0;
        Read_data_Ack = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 0;

        // Reset state; a stray response must be ignored
        mem_rsp_valid = 1; mem_rsp_data = 32'hA5A5_0001;
        tick(); sample();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_inst_ack", Inst_Req_Ack, 0);
        chk("rst_mem_ack", Mem_Req_Ack, 0);
        chk("rst_inst_valid", Inst_Valid, 0);
        chk("rst_rd_valid", Read_data_Valid, 0);
        chk("rst_rsp_ready", mem_rsp_ready, 0);
        chk("rst_wait_cnt", arb_wait_cnt, 0);
        chk("rst_tx_cnt", arb_tx_cnt, 0);
        chk("rst_instr_follow", Instruction, 32'hA5A5_0001);
        chk("rst_rdata_follow", Read_data, 32'hA5A5_0001);
        tick(); rst = 1; mem_rsp_valid = 0;

        // Single fetch
        tick(); PC = 32'h0000_0040; Inst_Req_Valid = 1; mem_req_ready = 1;
        sample(); chk("fetch_idle_valid", mem_req_valid, 0);
        tick(); sample();
        chk("fetch_req_valid", mem_req_valid, 1);
        chk("fetch_addr", mem_addr, 32'h40);
        chk("fetch_wr", mem_req_wr, 0);
        chk("fetch_wstrb", mem_wstrb, 0);
        chk("fetch_ack", Inst_Req_Ack, 1);
        chk("fetch_mem_ack", Mem_Req_Ack, 0);
        tick(); Inst_Req_Valid = 0; mem_req_ready = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'h2408_0005; Inst_Ack = 1;
        sample();
        chk("fetch_rsp_valid", Inst_Valid, 1);
        chk("fetch_instr", Instruction, 32'h2408_0005);
        chk("fetch_rsp_ready", mem_rsp_ready, 1);
        chk("fetch_rd_valid", Read_data_Valid, 0);
        chk("fetch_tx_cnt", arb_tx_cnt, 1);
        chk("fetch_wait_cnt", arb_wait_cnt, 1);
        tick(); mem_rsp_valid = 0; Inst_Ack = 0;
        sample();
        chk("fetch_done_valid", Inst_Valid, 0);
        chk("fetch_done_req", mem_req_valid, 0);

        // Store with 3 cycles of request backpressure
        do_reset();
        tick(); MemWrite = 1; Address = 32'h100; Write_data = 32'hDEAD_BEEF; Write_strb = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            chk("st_hold_valid", mem_req_valid, 1);
            chk("st_hold_addr", mem_addr, 32'h100);
            chk("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_hold_wstrb", mem_wstrb, 4'b0011);
            chk("st_hold_wr", mem_req_wr, 1);
            chk("st_hold_ack", Mem_Req_Ack, 0);
        end
        tick(); mem_req_ready = 1;
        sample();
        chk("st_ack", Mem_Req_Ack, 1);
        chk("st_inst_ack", Inst_Req_Ack, 0);
        tick(); MemWrite = 0; mem_req_ready = 0; mem_rsp_valid = 1;
        sample();
        chk("st_idle_valid", mem_req_valid, 0);
        chk("st_no_rsp_ready", mem_rsp_ready, 0);
        chk("st_no_rd_valid", Read_data_Valid, 0);
        chk("st_tx_cnt", arb_tx_cnt, 1);
        chk("st_wait_cnt", arb_wait_cnt, 4);
        mem_rsp_valid = 0;

        // Ties: first to fetch, then a tie with last=fetch goes to data
        do_reset();
        tick(); Inst_Req_Valid = 1; PC = 32'h80; MemRead = 1; Address = 32'h300; mem_req_ready = 1;
        sample(); chk("tie1_idle", mem_req_valid, 0);
        tick(); sample();
        chk("tie1_inst_ack", Inst_Req_Ack, 1);
        chk("tie1_mem_ack", Mem_Req_Ack, 0);
        chk("tie1_addr", mem_addr, 32'h80);
        tick(); PC = 32'h84; mem_rsp_valid = 1; mem_rsp_data = 32'h11; Inst_Ack = 1;
        sample();
        chk("tie1_inst_valid", Inst_Valid, 1);
        chk("tie1_rd_valid", Read_data_Valid, 0);
        chk("tie1_rsp_noack", Inst_Req_Ack | Mem_Req_Ack, 0);
        tick(); mem_rsp_valid = 0; Inst_Ack = 0;
        sample(); chk("tie2_idle", mem_req_valid, 0);
        tick(); sample();
        chk("tie2_mem_ack", Mem_Req_Ack, 1);
        chk("tie2_inst_ack", Inst_Req_Ack, 0);
        chk("tie2_addr", mem_addr, 32'h300);
        tick(); MemRead = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h22; Read_data_Ack = 1;
        sample();
        chk("tie2_rd_valid", Read_data_Valid, 1);
        chk("tie2_rdata", Read_data, 32'h22);
        chk("tie2_inst_valid", Inst_Valid, 0);
        tick(); mem_rsp_valid = 0; Read_data_Ack = 0;
        tick(); sample();
        chk("tie3_inst_ack", Inst_Req_Ack, 1);
        chk("tie3_addr", mem_addr, 32'h84);
        tick(); Inst_Req_Valid = 0; mem_rsp_valid = 1; Inst_Ack = 1;
        tick(); mem_rsp_valid = 0; Inst_Ack = 0;
        sample();
        chk("tie_tx_cnt", arb_tx_cnt, 3);
        chk("tie_wait_cnt", arb_wait_cnt, 5);

        // Load with response backpressure; a fetch arriving meanwhile waits
        do_reset();
        tick(); MemRead = 1; Address = 32'h200; mem_req_ready = 1;
        tick(); sample();
        chk("ld_ack", Mem_Req_Ack, 1);
        chk("ld_addr", mem_addr, 32'h200);
        chk("ld_wr", mem_req_wr, 0);
        tick(); MemRead = 0; Inst_Req_Valid = 1; PC = 32'h44;
        mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678; Read_data_Ack = 0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("ld_bp_valid", Read_data_Valid, 1);
            chk("ld_bp_data", Read_data, 32'h1234_5678);
            chk("ld_bp_ready", mem_rsp_ready, 0);
            chk("ld_bp_req", mem_req_valid, 0);
            chk("ld_bp_inst_ack", Inst_Req_Ack, 0);
            tick();
        end
        Read_data_Ack = 1;
        sample();
        chk("ld_last_valid", Read_data_Valid, 1);
        chk("ld_last_ready", mem_rsp_ready, 1);
        tick(); mem_rsp_valid = 0; Read_data_Ack = 0;
        sample();
        chk("ld_idle_req", mem_req_valid, 0);
        chk("ld_idle_rdv", Read_data_Valid, 0);
        tick(); sample();
        chk("ld_fetch_req", mem_req_valid, 1);
        chk("ld_fetch_addr", mem_addr, 32'h44);
        chk("ld_fetch_ack", Inst_Req_Ack, 1);
        tick(); Inst_Req_Valid = 0; mem_req_ready = 0; mem_rsp_valid = 1; Inst_Ack = 1;
        tick(); mem_rsp_valid = 0; Inst_Ack = 0;

        // Asynchronous reset in the middle of a request
        tick(); MemWrite = 1; Address = 32'h10; mem_req_ready = 1;
        tick(); #1;
        chk("mid_req_valid", mem_req_valid, 1);
        chk("mid_req_ack", Mem_Req_Ack, 1);
        rst = 0; #1;
        chk("mid_rst_valid", mem_req_valid, 0);
        chk("mid_rst_ack", Mem_Req_Ack, 0);
        chk("mid_rst_tx", arb_tx_cnt, 0);
        chk("mid_rst_wait", arb_wait_cnt, 0);
        MemWrite = 0; mem_req_ready = 0;
        tick(); rst = 1;
        tick(); sample();
        chk("post_rst_idle", mem_req_valid, 0);

        // Transaction counter wrap
        tick(); force dut.tx_cnt_q = 32'hFFFF_FFFF;
        MemRead = 1; Address = 32'h400; mem_req_ready = 1;
        sample(); release dut.tx_cnt_q;
        tick(); sample();
        chk("wrap_ack", Mem_Req_Ack, 1);
        chk("wrap_before", arb_tx_cnt, 32'hFFFF_FFFF);
        tick(); MemRead = 0; mem_req_ready = 0; mem_rsp_valid = 1; Read_data_Ack = 1;
        sample();
        chk("wrap_after", arb_tx_cnt, 0);
        tick(); mem_rsp_valid = 0; Read_data_Ack = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that lets `mips_cpu`'s instruction-fetch channel and data-memory channel share one unified memory port. It sits between the CPU and the single-ported memory/AXI bridge.

The block:
- serialises transactions with one outstanding at a time;
- arbitrates round-robin when both channels request together;
- converts the CPU's split ack/valid handshakes into one request/response protocol;
- exports wait/transaction counters for the perf-counter bank.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `PC`  in  32  fetch address.
- `Inst_Req_Valid`  in  1  fetch request, held until acked.
- `Inst_Req_Ack`  out  1  fetch request accepted (1-cycle pulse).
- `Instruction`  out  32  fetched word.
- `Inst_Valid`  out  1  fetch response valid.
- `Inst_Ack`  in  1  CPU consumes the fetch response.
- `Address`  in  32  data address.
- `MemRead`, `MemWrite`  in  1  data request; both held until acked.
- `Write_data`  in  32  store data.
- `Write_strb`  in  4  store byte strobes.
- `Mem_Req_Ack`  out  1  data request accepted (1-cycle pulse).
- `Read_data`  out  32  load data.
- `Read_data_Valid`  out  1  load response valid.
- `Read_data_Ack`  in  1  CPU consumes the load response.
- `mem_req_valid`  out  1  unified request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_wr`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  request address.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  write strobes.
- `mem_rsp_valid`  in  1  read response valid.
- `mem_rsp_data`  in  32  read response data.
- `mem_rsp_ready`  out  1  arbiter accepts the response.
- `arb_wait_cnt`  out  32  cycles a CPU request was pending but not yet accepted.
- `arb_tx_cnt`  out  32  accepted memory requests.

## Operation
States: `IDLE`, `REQ`, `RSP`. A 1-bit `owner` register holds 0 = inst, 1 = data; a 1-bit `last` register records the last granted owner.

`IDLE`:
- Sample `Inst_Req_Valid` and data request `dreq = MemRead|MemWrite`.
- If exactly one is set, grant it.
- If both are set, grant `!last`.
- On grant:
  - latch addr/wdata/wstrb/wr into registers (fetch: wr=0, wstrb=0);
  - set `owner` and `last`;
  - go to `REQ`.
- With no request, stay in `IDLE`.

`MemRead` and `MemWrite` both high is treated as a write (`MemWrite` wins).

`REQ`:
- `mem_req_valid=1`; fields come from the latched registers.
- On `mem_req_valid & mem_req_ready`:
  - pulse `Inst_Req_Ack` or `Mem_Req_Ack` for `owner`, combinationally, in the same cycle;
  - a write goes to `IDLE`;
  - a read goes to `RSP`.

`RSP`:
- Forward `mem_rsp_valid` to `Inst_Valid` or `Read_data_Valid` for `owner`.
- `mem_rsp_data` drives `Instruction` and `Read_data` combinationally.
- `mem_rsp_ready` = the owner's `Inst_Ack` / `Read_data_Ack`.
- On `mem_rsp_valid & mem_rsp_ready`, go to `IDLE`.
- `mem_rsp_valid` outside `RSP` is ignored; `mem_rsp_ready=0` there.

Counters:
- `arb_wait_cnt` increments each cycle where (`Inst_Req_Valid` or `dreq`) and no CPU request-ack is pulsed.
- `arb_tx_cnt` increments on each `mem_req_valid & mem_req_ready`.
- Both wrap modulo 2^32.

## Timing
- Reset: asynchronous assert, synchronous-release assumption.
  - state=`IDLE`, `last`=1 (first tie goes to inst), `owner`=0.
  - Latched request registers and counters = 0.
  - All valid/ack/ready outputs = 0.
  - `Instruction` and `Read_data` follow `mem_rsp_data`.
- Reset mid-transaction aborts the transaction. The memory side shares this reset, so no stale response is returned.
- Minimum latency from CPU request high in `IDLE`:
  - `mem_req_valid` rises 1 cycle later;
  - the CPU ack fires in that same cycle if `mem_req_ready=1`.
- Zero-wait read: the CPU sees response valid 1 cycle after its request ack.
- Write throughput: 1 write every 2 cycles. Read throughput: 1 read every 3 cycles.
- `mem_req_*` fields are stable while `mem_req_valid=1` until accepted. The CPU may drop or change its request after its ack pulse without effect.
- Backpressure: `mem_req_ready` or CPU ack held low keeps the arbiter in `REQ`/`RSP` indefinitely, with no timeout.
- The CPU-side request ack is never asserted for a requester that is not `owner`.

## Test plan
- **Reset:** `rst`=0 asynchronously mid-`REQ` → all valid/ack outputs 0 immediately; counters 0; after release, state `IDLE`.
- **Single fetch:**
  - Stimulus: PC=0x0000_0040, `Inst_Req_Valid`=1, `mem_req_ready`=1.
  - Cycle 1: `mem_req_valid`=1, `mem_addr`=0x40, `mem_req_wr`=0, `Inst_Req_Ack` pulse.
  - Cycle 2: with `mem_rsp_valid`=1 and data 0x2408_0005 → `Inst_Valid`=1, `Instruction`=0x2408_0005; completes on `Inst_Ack`.
- **Store:**
  - Stimulus: `MemWrite`=1, `Address`=0x100, `Write_data`=0xDEAD_BEEF, `Write_strb`=4'b0011, `mem_req_ready` low for 3 cycles.
  - Response: `mem_req_valid` held with constant fields for 3 cycles; `Mem_Req_Ack` one pulse; back to `IDLE` with no `RSP` state; `arb_tx_cnt`=1, `arb_wait_cnt`=4.
- **Simultaneous requests:**
  - Stimulus: both requests high in `IDLE` after reset.
  - Response: inst granted first, then data. A second tie grants data first.
- **Load with response backpressure:** `MemRead` at 0x200, response 0x1234_5678, `Read_data_Ack` low 2 cycles → `Read_data_Valid` held 3 cycles, `mem_rsp_ready` tracks `Read_data_Ack`; a fetch request arriving meanwhile waits until `IDLE`.
- **Counter wrap:** preload `arb_tx_cnt`=0xFFFF_FFFF by force, issue 1 request → reads 0.
